// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID stage: opcodes, ALU op encodings and ID/EX control bundle.
// An all-zero id_ex_ctrl_t is a pipeline bubble.
package mips_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI);
  endfunction

  function automatic id_ex_ctrl_t decode_ctrl(input logic [5:0] op);
    id_ex_ctrl_t c;
    c = CTRL_BUBBLE;
    case (op)
      OP_RTYPE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = ALU_FUNCT; end
      OP_LW: begin
        c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
        c.alu_src = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_SW:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
      OP_BEQ,
      OP_BNE:  c.alu_op = ALU_SUB;
      OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 2-read/1-write register file, r0 hardwired to zero, async active-low reset.
// DECODE_WB_BYPASS_EN: a same-cycle WB write is forwarded to the matching read port.
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int XLEN = XLEN_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_a_i,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef DECODE_WB_BYPASS_EN
    if (we_i && (waddr_i != '0) && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (we_i && (waddr_i != '0) && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, register read, in-ID branch resolution, hazard stall, ID/EX register.
// DECODE_WB_BYPASS_EN enables same-cycle WB-to-ID forwarding inside the register file.
module decode_stage
  import mips_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_id_pc_plus4,
  input  logic [31:0]     if_id_instr,
  input  logic            wb_we,
  input  logic [4:0]      wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            exmem_mem_read,
  input  logic [4:0]      exmem_rd,
  output logic            stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_addr,
  output logic [XLEN-1:0] id_ex_pc_plus4,
  output logic [XLEN-1:0] id_ex_rs_data,
  output logic [XLEN-1:0] id_ex_rt_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs,
  output logic [4:0]      id_ex_rt,
  output logic [4:0]      id_ex_rd,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_mem_to_reg,
  output logic            id_ex_alu_src,
  output logic            id_ex_reg_dst,
  output logic [1:0]      id_ex_alu_op,
  output logic            illegal
);

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd, ex_dest;
  logic [XLEN-1:0] imm, rs_val, rt_val;
  logic            is_beq, is_bne, is_branch, uses_rt;
  logic            load_use, br_on_ex, br_on_mem;
  id_ex_ctrl_t     ctrl_dec, ctrl_q;
  logic [XLEN-1:0] pc_plus4_q, rs_data_q, rt_data_q, imm_q;
  logic [4:0]      rs_q, rt_q, rd_q;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign imm    = {{(XLEN-16){if_id_instr[15]}}, if_id_instr[15:0]};

  assign illegal  = !op_supported(opcode);
  assign ctrl_dec = decode_ctrl(opcode);

  regfile_2r1w #(.NREG(NREG), .XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_we),
    .waddr_i   (wb_waddr),
    .wdata_i   (wb_wdata),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val)
  );

  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_branch = is_beq || is_bne;
  assign uses_rt   = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_branch;

  // Branches compare in ID, so they must wait for any operand still in EX or a load in MEM.
  assign ex_dest   = ctrl_q.reg_dst ? rd_q : rt_q;
  assign load_use  = ctrl_q.mem_read && (rt_q != '0) &&
                     ((rt_q == rs) || (uses_rt && (rt_q == rt)));
  assign br_on_ex  = is_branch && ctrl_q.reg_write && (ex_dest != '0) &&
                     ((ex_dest == rs) || (ex_dest == rt));
  assign br_on_mem = is_branch && exmem_mem_read && (exmem_rd != '0) &&
                     ((exmem_rd == rs) || (exmem_rd == rt));
  assign stall     = load_use || br_on_ex || br_on_mem;

  assign branch_taken = !stall && ((is_beq && (rs_val == rt_val)) ||
                                   (is_bne && (rs_val != rt_val)));
  assign branch_addr  = if_id_pc_plus4 + (imm << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_BUBBLE;
      pc_plus4_q <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else begin
      pc_plus4_q <= if_id_pc_plus4;
      rs_data_q  <= rs_val;
      rt_data_q  <= rt_val;
      imm_q      <= imm;
      if (stall) begin
        ctrl_q <= CTRL_BUBBLE;
        rs_q   <= '0;
        rt_q   <= '0;
        rd_q   <= '0;
      end else begin
        ctrl_q <= ctrl_dec;
        rs_q   <= rs;
        rt_q   <= rt;
        rd_q   <= rd;
      end
    end
  end

  assign id_ex_pc_plus4   = pc_plus4_q;
  assign id_ex_rs_data    = rs_data_q;
  assign id_ex_rt_data    = rt_data_q;
  assign id_ex_imm        = imm_q;
  assign id_ex_rs         = rs_q;
  assign id_ex_rt         = rt_q;
  assign id_ex_rd         = rd_q;
  assign id_ex_reg_write  = ctrl_q.reg_write;
  assign id_ex_mem_read   = ctrl_q.mem_read;
  assign id_ex_mem_write  = ctrl_q.mem_write;
  assign id_ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign id_ex_alu_src    = ctrl_q.alu_src;
  assign id_ex_reg_dst    = ctrl_q.reg_dst;
  assign id_ex_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table plus hand sequences, ID/EX checked via scoreboard.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id_pc_plus4, if_id_instr, wb_wdata, branch_addr;
  logic        wb_we, exmem_mem_read, stall, branch_taken, illegal;
  logic [4:0]  wb_waddr, exmem_rd;
  logic [31:0] id_ex_pc_plus4, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
  logic        id_ex_alu_src, id_ex_reg_dst;
  logic [1:0]  id_ex_alu_op;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd),
    .stall(stall), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .id_ex_pc_plus4(id_ex_pc_plus4), .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_reg_dst(id_ex_reg_dst),
    .id_ex_alu_op(id_ex_alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Control byte layout: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op}
  localparam logic [7:0] C_R = 8'h86, C_ADDI = 8'h88, C_BR = 8'h01, C_SW = 8'h28, C_LW = 8'hD8;
  localparam logic [7:0] C_NONE = 8'h00;

  typedef struct {
    logic [31:0] pc4, instr;
    logic [7:0]  ctrl;
    logic        ill, stl, bt, chk_ba;
    logic [31:0] ba;
  } vec_t;

  typedef struct {
    int          tag;
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic        chk_data;
    logic [31:0] pc4, imm, rsd, rtd;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          tag = 0;
  logic [31:0] mregs [32];
  exp_t        sb [$];
  vec_t        vecs [10];

  function automatic logic [7:0] ctrl_out();
    return {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
            id_ex_alu_src, id_ex_reg_dst, id_ex_alu_op};
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we && wb_waddr == idx) return wb_wdata;
`endif
    return mregs[idx];
  endfunction

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic cycle(input logic [7:0] ctrl, input logic ill, input logic stl,
                       input logic bt, input logic chk_ba, input logic [31:0] ba);
    exp_t e, g;
    tag++;
    #3;
    chk("stall", tag, {31'b0, stall}, {31'b0, stl});
    chk("branch_taken", tag, {31'b0, branch_taken}, {31'b0, bt});
    chk("illegal", tag, {31'b0, illegal}, {31'b0, ill});
    if (chk_ba) chk("branch_addr", tag, branch_addr, ba);
    e.tag = tag;
    if (stl) begin
      e.ctrl = C_NONE; e.rs = 5'd0; e.rt = 5'd0; e.rd = 5'd0; e.chk_data = 1'b0;
      e.pc4 = '0; e.imm = '0; e.rsd = '0; e.rtd = '0;
    end else begin
      e.ctrl = ctrl;
      e.rs = if_id_instr[25:21]; e.rt = if_id_instr[20:16]; e.rd = if_id_instr[15:11];
      e.chk_data = 1'b1;
      e.pc4 = if_id_pc_plus4;
      e.imm = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
      e.rsd = mread(if_id_instr[25:21]);
      e.rtd = mread(if_id_instr[20:16]);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (wb_we && wb_waddr != 5'd0) mregs[wb_waddr] = wb_wdata;
    g = sb.pop_front();
    chk("id_ex_ctrl", g.tag, {24'b0, ctrl_out()}, {24'b0, g.ctrl});
    chk("id_ex_rs", g.tag, {27'b0, id_ex_rs}, {27'b0, g.rs});
    chk("id_ex_rt", g.tag, {27'b0, id_ex_rt}, {27'b0, g.rt});
    chk("id_ex_rd", g.tag, {27'b0, id_ex_rd}, {27'b0, g.rd});
    if (g.chk_data) begin
      chk("id_ex_pc_plus4", g.tag, id_ex_pc_plus4, g.pc4);
      chk("id_ex_imm", g.tag, id_ex_imm, g.imm);
      chk("id_ex_rs_data", g.tag, id_ex_rs_data, g.rsd);
      chk("id_ex_rt_data", g.tag, id_ex_rt_data, g.rtd);
    end
  endtask

  task automatic check_bubble_now(input string name);
    chk({name, "_ctrl"}, tag, {24'b0, ctrl_out()}, 32'h0);
    chk({name, "_idx"}, tag, {17'b0, id_ex_rs, id_ex_rt, id_ex_rd}, 32'h0);
    chk({name, "_data"}, tag, id_ex_pc_plus4 | id_ex_imm | id_ex_rs_data | id_ex_rt_data, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    rst_n = 1'b0;
    if_id_pc_plus4 = '0; if_id_instr = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    exmem_mem_read = 1'b0; exmem_rd = '0;

    vecs[0] = '{32'h0000_0000, 32'h2001FFFC, C_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0100, 32'h10850003, C_BR,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_010C};
    vecs[2] = '{32'h0000_0100, 32'h14850003, C_BR,   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_010C};
    vecs[3] = '{32'h0000_0104, 32'hAC850008, C_SW,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_0108, 32'hFC000000, C_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{32'h0000_0200, 32'h1080FFFF, C_BR,   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_01FC};
    vecs[6] = '{32'h0000_0200, 32'h1480FFFF, C_BR,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_01FC};
    vecs[7] = '{32'h0000_0204, 32'h00851820, C_R,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{32'h0000_0300, 32'h10600001, C_BR,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[9] = '{32'h0000_0300, 32'h10600001, C_BR,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0304};

    #2;
    check_bubble_now("reset");
    chk("reset_stall", tag, {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Preload r4=7, r5=7, r9=0x1234 via WB while ID decodes NOPs.
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'd7;
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    wb_waddr = 5'd5;
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    wb_waddr = 5'd9; wb_wdata = 32'h0000_1234;
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    wb_we = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if_id_pc_plus4 = vecs[i].pc4;
      if_id_instr    = vecs[i].instr;
      cycle(vecs[i].ctrl, vecs[i].ill, vecs[i].stl, vecs[i].bt, vecs[i].chk_ba, vecs[i].ba);
    end

    // Load-use: lw r2,0(r1) then add r3,r2,r2 stalls exactly once.
    if_id_pc_plus4 = 32'h400; if_id_instr = 32'h8C220000;
    cycle(C_LW, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    if_id_pc_plus4 = 32'h404; if_id_instr = 32'h00421820;
    cycle(C_R, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Branch operand produced by a load currently in MEM.
    if_id_pc_plus4 = 32'h100; if_id_instr = 32'h10850003;
    exmem_mem_read = 1'b1; exmem_rd = 5'd4;
    cycle(C_BR, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    exmem_mem_read = 1'b0; exmem_rd = 5'd0;
    cycle(C_BR, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_010C);

    // WB write of r9 in the same cycle ID reads it.
    if_id_pc_plus4 = 32'h500; if_id_instr = 32'h01205020;
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h0000_DEAD;
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    wb_we = 1'b0;
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Writes to r0 are ignored.
    if_id_instr = 32'h00005820;
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h0000_FFFF;
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    wb_we = 1'b0;
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-run while ID/EX holds a register writer.
    chk("pre_reset_reg_write", tag, {31'b0, id_ex_reg_write}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bubble_now("async_reset");
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    if_id_pc_plus4 = 32'h600; if_id_instr = 32'h00A06020;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(C_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch; consumes the IF/ID register contents (PC+4, instruction).
- Holds the 32x32 register file (written from WB), decodes main control, sign-extends the immediate, resolves beq/bne in ID and returns branch_taken/branch_addr to the fetch PC mux.
- Detects load-use and branch-operand hazards, asserts stall, and drives the registered ID/EX pipeline register.

Parameters:
- NREG, 32, register-file depth (5-bit index).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_id_pc_plus4  in  32  PC+4 from IF/ID
- if_id_instr  in  32  instruction from IF/ID
- wb_we  in  1  WB register write enable
- wb_waddr  in  5  WB destination
- wb_wdata  in  32  WB data
- exmem_mem_read  in  1  instruction in MEM is a load
- exmem_rd  in  5  destination of instruction in MEM
- stall  out  1  hold PC and IF/ID this cycle
- branch_taken  out  1  select branch_addr at fetch PC mux
- branch_addr  out  32  branch target
- id_ex_pc_plus4, id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  32 each  registered operands
- id_ex_rs, id_ex_rt, id_ex_rd  out  5 each  registered register indices
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src, id_ex_reg_dst  out  1 each  registered control
- id_ex_alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- illegal  out  1  combinational: opcode not supported

Behaviour:
- Reset (async, rst_n=0): all id_ex_* outputs 0 (bubble), all registers 0. Released synchronously on the next clk edge.
- Register file: write on posedge when wb_we && wb_waddr!=0; r0 reads 0 always. Reads are combinational.
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08. Any other opcode: illegal=1, decoded as NOP (all control 0).
- imm = sign-extend(instr[15:0]) to 32 bits. branch_addr = if_id_pc_plus4 + (imm<<2), modulo 2^32.
- Branch: branch_taken = !stall && ((beq && rs_val==rt_val) || (bne && rs_val!=rt_val)). Architected one-instruction delay slot: the instruction after a branch always executes; no flush.
- Hazard (stall=1) when any of the following holds:
  - load-use: id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==rs || (uses_rt && id_ex_rt==rt)), where uses_rt holds for R-type, sw, beq and bne;
  - branch-on-EX-writer: branch && id_ex_reg_write && dest!=0 && dest∈{rs,rt}, with dest = reg_dst ? rd : rt of the registered instruction;
  - branch-on-MEM-load: branch && exmem_mem_read && exmem_rd!=0 && exmem_rd∈{rs,rt}.
- On stall: ID/EX loads a bubble (all control 0, data don't-care, rs/rt/rd 0); the IF/ID content is re-presented by fetch on the next cycle.
- Otherwise ID/EX loads the decoded instruction each posedge. Latency: one cycle from IF/ID to ID/EX.
- Simultaneous WB write and ID read of the same register: governed by the optional feature below.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: if wb_we && wb_waddr!=0 && wb_waddr==rs (or rt), that read port returns wb_wdata in the same cycle, for both branch compare and ID/EX capture.
- Undefined: the read returns the old register value; software/compiler inserts a NOP between the WB writer and a reader three instructions later.

Decomposition:
- Package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI), ALU_OP encodings, and an id_ex control struct typedef (all-zero value = bubble).
- Sub-module regfile_2r1w: 2 async read ports, 1 sync write port, r0 hardwired, async reset, bypass under DECODE_WB_BYPASS_EN.

Test Plan:
- Reset mid-run: assert rst_n=0 while id_ex_reg_write=1 -> all id_ex_* become 0 immediately, without waiting for a clk edge; r5 reads 0 afterwards.
- addi r1,r0,-4 (0x2001FFFC) -> next edge: id_ex_imm=0xFFFFFFFC, reg_write=1, alu_src=1, alu_op=00, illegal=0.
- lw r2,0(r1) followed by add r3,r2,r2 -> stall=1 for exactly one cycle, ID/EX holds a bubble, then the add is issued.
- r4=r5=7, beq r4,r5,+3 with pc_plus4=0x100 -> branch_taken=1, branch_addr=0x10C. bne with the same operands -> branch_taken=0.
- beq whose rs matches a load in MEM (exmem_mem_read=1, exmem_rd=rs) -> stall=1 and branch_taken=0 in that cycle.
- WB writes r9=0xDEAD while ID reads r9 -> 0xDEAD with DECODE_WB_BYPASS_EN defined, old value without it. A write to r0 is always ignored.
